// File: rtl/fifo_thresh.sv
// fifo_thresh -- single-clock FIFO with arbitrary depth, programmable
// almost-full/almost-empty thresholds, an occupancy count and sticky
// overflow/underflow error flags.
//
// Compile-time option:
//   FIFO_FWFT_EN  defined   -> first-word-fall-through: the head word is shown
//                              on data_out whenever the FIFO is not empty, and
//                              rd_en pops it.
//                 undefined -> standard mode: data_out is a register that loads
//                              the head word on an accepted read (1-cycle latency).
//
// Parameters:
//   N         data width (>= 1)
//   M         depth in words (>= 2, any integer)
//   AF_LEVEL  almost_full  when count >= AF_LEVEL (1..M)
//   AE_LEVEL  almost_empty when count <= AE_LEVEL (0..M-1)
//   CW        width of count, $clog2(M+1)
//
// Ports:
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   wr_en         write request; data_in sampled with it
//   data_in       write data
//   rd_en         read request
//   data_out      read data
//   status_full   count == M
//   status_empty  count == 0
//   half_full     count >= M/2
//   almost_full   count >= AF_LEVEL
//   almost_empty  count <= AE_LEVEL
//   count         current occupancy 0..M
//   overflow      sticky: a write was dropped
//   underflow     sticky: a read was rejected
//   clr_err       synchronous clear of overflow and underflow
module fifo_thresh #(
  parameter int N        = 8,
  parameter int M        = 4,
  parameter int AF_LEVEL = M - 1,
  parameter int AE_LEVEL = 1,
  localparam int CW      = $clog2(M + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [N-1:0]  data_in,
  input  logic          rd_en,
  output logic [N-1:0]  data_out,
  output logic          status_full,
  output logic          status_empty,
  output logic          half_full,
  output logic          almost_full,
  output logic          almost_empty,
  output logic [CW-1:0] count,
  output logic          overflow,
  output logic          underflow,
  input  logic          clr_err
);

  localparam int PW = $clog2(M);
  localparam logic [PW-1:0] PTR_LAST = PW'(M - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(M);
  localparam logic [CW-1:0] CNT_HALF = CW'(M / 2);
  localparam logic [CW-1:0] CNT_AF   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] CNT_AE   = CW'(AE_LEVEL);

  logic [N-1:0]  mem [0:M-1];

  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] count_reg, count_next;
  logic          overflow_reg, overflow_next;
  logic          underflow_reg, underflow_next;
  logic          rd_acc, wr_acc;

  // A read frees a slot in the same edge, so a full FIFO still accepts a
  // write when a read is accepted alongside it.
  assign rd_acc = rd_en && (count_reg != '0);
  assign wr_acc = wr_en && ((count_reg != CNT_FULL) || rd_acc);

  always_comb begin
    wr_ptr_next    = wr_ptr_reg;
    rd_ptr_next    = rd_ptr_reg;
    count_next     = count_reg;
    overflow_next  = overflow_reg;
    underflow_next = underflow_reg;

    // Explicit wrap: depth need not be a power of two.
    if (wr_acc) begin
      wr_ptr_next = (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + PW'(1);
    end
    if (rd_acc) begin
      rd_ptr_next = (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + PW'(1);
    end

    case ({wr_acc, rd_acc})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase

    // Clear first, then let a same-cycle error event re-set the flag.
    if (clr_err) begin
      overflow_next  = 1'b0;
      underflow_next = 1'b0;
    end
    if (wr_en && !wr_acc) overflow_next  = 1'b1;
    if (rd_en && !rd_acc) underflow_next = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      count_reg     <= count_next;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
    end
  end

  // Storage is never reset; its contents are unobservable until written.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr_reg] <= data_in;
    end
  end

`ifdef FIFO_FWFT_EN
  // Head word is shown directly; forced to zero while empty so reset and
  // empty states present a clean value.
  assign data_out = status_empty ? '0 : mem[rd_ptr_reg];
`else
  logic [N-1:0] data_out_reg;

  // On a full+read+write edge rd_ptr == wr_ptr; the non-blocking write means
  // the old (oldest) word is captured here, not the incoming one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out_reg <= '0;
    end else if (rd_acc) begin
      data_out_reg <= mem[rd_ptr_reg];
    end
  end

  assign data_out = data_out_reg;
`endif

  // All status outputs decode the registered count only.
  assign count        = count_reg;
  assign status_full  = (count_reg == CNT_FULL);
  assign status_empty = (count_reg == '0);
  assign half_full    = (count_reg >= CNT_HALF);
  assign almost_full  = (count_reg >= CNT_AF);
  assign almost_empty = (count_reg <= CNT_AE);
  assign overflow     = overflow_reg;
  assign underflow    = underflow_reg;

endmodule

// File: doc/fifo_thresh.md
# fifo_thresh

Parametrised synchronous FIFO: next generation of the team's fixed-flag FIFO, with arbitrary (non-power-of-two) depth, programmable almost-full/almost-empty thresholds, an occupancy count output and sticky overflow/underflow error flags. Single-clock buffer placed between a producer and a consumer in the same clock domain. Optional first-word-fall-through read mode selected at compile time.

## Interface
- N, 8: data width in bits, N >= 1
- M, 4: depth in words, M >= 2, any integer (need not be a power of two)
- AF_LEVEL, M-1: almost_full asserts when count >= AF_LEVEL; 1 <= AF_LEVEL <= M
- AE_LEVEL, 1: almost_empty asserts when count <= AE_LEVEL; 0 <= AE_LEVEL < M
- CW: localparam, $clog2(M+1), width of count

Ports; one clock; reset is asynchronous and active-low:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- wr_en  input  1  write request
- data_in  input  N  write data, sampled with wr_en
- rd_en  input  1  read request
- data_out  output  N  read data
- status_full  output  1  count == M
- status_empty  output  1  count == 0
- half_full  output  1  count >= M/2 (integer division)
- almost_full  output  1  count >= AF_LEVEL
- almost_empty  output  1  count <= AE_LEVEL
- count  output  CW  current occupancy, 0..M
- overflow  output  1  sticky: a write was dropped
- underflow  output  1  sticky: a read was rejected
- clr_err  input  1  synchronous clear of overflow and underflow

## Operation
- Storage: M-entry array; wr_ptr and rd_ptr range 0..M-1 and wrap from M-1 to 0 by explicit compare (no modulo-2^k wrap).
- Write accepted (wr_acc) = wr_en && (!status_full || rd_acc). Accepted write stores data_in at wr_ptr, advances wr_ptr.
- Read accepted (rd_acc) = rd_en && !status_empty. Accepted read advances rd_ptr.
- Full + wr_en + rd_en: both accepted, count unchanged, oldest word leaves, new word stored in the freed slot.
- Empty + wr_en + rd_en: write accepted, read rejected, underflow set (no bypass in standard mode).
- count: +1 on write only, -1 on read only, unchanged on both or neither; never exceeds M or goes below 0.
- wr_en && !wr_acc: data dropped, storage and pointers untouched, overflow <= 1.
- rd_en && !rd_acc: data_out holds, underflow <= 1.
- clr_err clears both sticky flags; an error event in the same cycle as clr_err wins (flag stays 1).
- All status flags are pure decodes of the registered count.
- Reset (asynchronous, any time, including mid-burst): pointers 0, count 0, data_out 0, status_empty 1, almost_empty 1, all other outputs 0; storage contents need not be cleared and are unobservable.

## Timing
- Standard mode: data_out is registered; loads mem[rd_ptr] on the rising edge where rd_acc = 1, valid from that edge; holds otherwise. Read latency 1 cycle.
- Write-to-readable: word written on edge k may be read (rd_acc) on edge k+1.
- Flags and count reflect the state after the most recent edge; no combinational path from wr_en/rd_en to any output.
- Overflow/underflow assert one edge after the offending request.

## Configuration
- FIFO_FWFT_EN defined: first-word-fall-through. data_out = mem[rd_ptr] whenever status_empty = 0 (head word visible without a read); rd_en acknowledges/pops the displayed word. A write into an empty FIFO is visible on data_out after that write edge. data_out is don't-care while empty. Still no empty-bypass: read while empty is rejected and sets underflow.
- FIFO_FWFT_EN undefined: standard registered read as described above.

## Test plan
- Reset: assert rst_n = 0 mid-sequence while count = 3 -> immediately count = 0, status_empty = 1, almost_empty = 1, data_out = 0, overflow = underflow = 0.
- Fill/drain, M = 4, N = 8: write 0x01..0x04 on 4 edges -> status_full = 1, count = 4, almost_full = 1 from count 3; read 4 times -> data_out 0x01, 0x02, 0x03, 0x04 in order, status_empty = 1 after the last.
- Wrap, M = 5 (non-power-of-two): 12 interleaved writes 0x01..0x0C and reads, count oscillating 0..5 -> read order exactly 0x01..0x0C, no drops, no error flags.
- Full + simultaneous: full with 0x01..0x04, wr_en = rd_en = 1 with data_in 0x05 -> data_out = 0x01, count stays 4, overflow = 0; subsequent drain yields 0x02, 0x03, 0x04, 0x05.
- Errors: write 0x09 while full (no read) -> overflow = 1, later drain omits 0x09; read while empty -> underflow = 1, data_out holds; pulse clr_err -> both 0; clr_err coincident with a new overflow -> overflow stays 1.
- FWFT build: write 0xA5 into empty FIFO -> data_out = 0xA5 after that edge with no rd_en; rd_en = 1 -> status_empty = 1, count = 0.
